// File: rtl/fft_sequencer.sv
// Frame sequencer for an in-place radix-2 DIT FFT: load, log2(N) butterfly stages, unload.
// Generates butterfly read/twiddle addresses and the delayed write-back strobes.
module fft_sequencer #(
    parameter int N             = 32,
    parameter int address_width = $clog2(N),
    parameter int BF_LATENCY    = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             load_done,
    input  logic                             unload_done,
    output logic                             load_en,
    output logic                             unload_en,
    output logic                             rd_en,
    output logic [address_width-1:0]         rd_addr1,
    output logic [address_width-1:0]         rd_addr2,
    output logic [address_width-2:0]         tw_addr,
    output logic                             wr_en,
    output logic [address_width-1:0]         wr_addr1,
    output logic [address_width-1:0]         wr_addr2,
    output logic [$clog2(address_width)-1:0] stage,
    output logic                             busy,
    output logic                             done
);
    localparam int SW = $clog2(address_width);
    localparam int KW = address_width - 1;
    localparam int DW = $clog2(BF_LATENCY + 1);

    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(address_width - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, FINISH} state_t;

    typedef struct packed {
        logic                     valid;
        logic [address_width-1:0] a1;
        logic [address_width-1:0] a2;
    } wb_t;

    state_t                   state, state_n;
    logic [KW-1:0]            k, k_n;
    logic [DW-1:0]            drain_cnt, drain_n;
    logic [SW-1:0]            stage_n;
    logic                     issue_n;
    logic [address_width-1:0] kw_n, mask_n, a1_n, a2_n;
    logic [KW-1:0]            tw_n;
    wb_t                      pipe [BF_LATENCY];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n = state;
        k_n     = k;
        drain_n = drain_cnt;
        stage_n = stage;
        issue_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (load_done) begin
                    state_n = COMPUTE;
                    stage_n = '0;
                    k_n     = '0;
                    issue_n = 1'b1;
                end
            end
            COMPUTE: begin
                if (k == K_LAST) begin
                    state_n = DRAIN;
                    drain_n = '0;
                end else begin
                    k_n     = k + 1'b1;
                    issue_n = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == D_LAST) begin
                    if (stage == S_LAST) begin
                        state_n = UNLOAD;
                    end else begin
                        state_n = COMPUTE;
                        stage_n = stage + 1'b1;
                        k_n     = '0;
                        issue_n = 1'b1;
                    end
                end else begin
                    drain_n = drain_cnt + 1'b1;
                end
            end
            UNLOAD: begin
                if (unload_done) state_n = FINISH;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand address inserts a zero at bit 'stage' of k: bits above shift up, j = k mod 2^stage stays.
    always_comb begin
        kw_n   = {1'b0, k_n};
        mask_n = (address_width'(1) << stage_n) - address_width'(1);
        a1_n   = ((kw_n & ~mask_n) << 1) | (kw_n & mask_n);
        a2_n   = a1_n | (address_width'(1) << stage_n);
        tw_n   = KW'((kw_n & mask_n) << (KW - int'(stage_n)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
            stage     <= '0;
            load_en   <= 1'b0;
            unload_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr1  <= '0;
            rd_addr2  <= '0;
            tw_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr1  <= '0;
            wr_addr2  <= '0;
            // NOTE: the write-delay pipe is cleared so an aborted frame cannot write back after reset.
            for (int i = 0; i < BF_LATENCY; i++) pipe[i] <= '0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            drain_cnt <= drain_n;
            stage     <= stage_n;
            load_en   <= (state_n == LOAD);
            unload_en <= (state_n == UNLOAD);
            busy      <= (state_n != IDLE);
            done      <= (state_n == FINISH);
            rd_en     <= issue_n;
            if (issue_n) begin
                rd_addr1 <= a1_n;
                rd_addr2 <= a2_n;
                tw_addr  <= tw_n;
            end
            // pipe[0] mirrors the read being issued; the tail feeds the registered write strobe.
            pipe[0] <= '{valid: issue_n, a1: a1_n, a2: a2_n};
            for (int i = 1; i < BF_LATENCY; i++) pipe[i] <= pipe[i-1];
            wr_en <= pipe[BF_LATENCY-1].valid;
            if (pipe[BF_LATENCY-1].valid) begin
                wr_addr1 <= pipe[BF_LATENCY-1].a1;
                wr_addr2 <= pipe[BF_LATENCY-1].a2;
            end
        end
    end
endmodule
